// File: rtl/i2c_pkg.sv
// Shared types and constants for the LM75 I2C poll scheduler.
// Optional TEMP_ALARM_EN macro adds the threshold alarm in the top.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    ISSUE,
    WAIT,
    STORE
  } state_t;

  localparam logic [6:0] LM75_BASE_ADDR = 7'b1001_000;
  localparam int DEF_POLL_CYCLES = 50_000_000;
  localparam int DEF_TIMEOUT_CYCLES = 20_000;

endpackage

// File: rtl/poll_timer.sv
// Free-running sweep timer; tick marks the terminal count.
// Never stalls, whatever the scheduler is doing.
module poll_timer
  import i2c_pkg::*;
#(
  parameter int POLL_CYCLES = DEF_POLL_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(POLL_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/i2c_poll_sched.sv
// Sweeps enabled LM75 sensors through an I2C read engine each tick.
// Define TEMP_ALARM_EN to add the thresh input and alarm output.
module i2c_poll_sched
  import i2c_pkg::*;
#(
  parameter int N_SENS = 4,
  parameter int POLL_CYCLES = DEF_POLL_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [6:0] BASE_ADDR = LM75_BASE_ADDR
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_SENS-1:0]      sens_en,
  output logic                   eng_start,
  output logic [6:0]             eng_addr,
  input  logic                   eng_busy,
  input  logic                   eng_done,
  input  logic                   eng_nack,
  input  logic [15:0]            eng_data,
  output logic [16*N_SENS-1:0]   temp,
  output logic [N_SENS-1:0]      valid,
  output logic [N_SENS-1:0]      err,
`ifdef TEMP_ALARM_EN
  input  logic signed [8:0]      thresh,
  output logic [N_SENS-1:0]      alarm,
`endif
  output logic                   sweep_done
);

  localparam int IW = (N_SENS > 1) ? $clog2(N_SENS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_SENS - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [N_SENS-1:0] en_q;
  logic [TW-1:0] wcnt;
  logic [15:0] data_q;
  logic nack_q;
  logic tick;

  logic last, advance;
  logic en_load, addr_load;
  logic wcnt_clr, wcnt_inc;
  logic cap, set_err, set_good;

  poll_timer #(
    .POLL_CYCLES(POLL_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    last       = (idx == LAST_IDX);
    advance    = 1'b0;
    en_load    = 1'b0;
    addr_load  = 1'b0;
    wcnt_clr   = 1'b0;
    wcnt_inc   = 1'b0;
    cap        = 1'b0;
    set_err    = 1'b0;
    set_good   = 1'b0;
    eng_start  = 1'b0;
    sweep_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (tick && (|sens_en)) begin
          en_load = 1'b1;
          idx_n   = '0;
          state_n = SELECT;
        end
      end
      SELECT: begin
        if (en_q[idx]) begin
          addr_load = 1'b1;
          state_n   = ISSUE;
        end else if (last) begin
          sweep_done = 1'b1;
          state_n    = IDLE;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      ISSUE: begin
        if (!eng_busy) begin
          eng_start = 1'b1;
          wcnt_clr  = 1'b1;
          state_n   = WAIT;
        end
      end
      WAIT: begin
        if (eng_done) begin
          cap     = 1'b1;
          state_n = STORE;
        end else if (wcnt == TO_LAST) begin
          // timeout: flag the sensor and move on exactly like STORE
          set_err = 1'b1;
          advance = 1'b1;
        end else begin
          wcnt_inc = 1'b1;
        end
      end
      STORE: begin
        set_err  = nack_q;
        set_good = !nack_q;
        advance  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (advance) begin
      if (last) begin
        sweep_done = 1'b1;
        state_n    = IDLE;
      end else begin
        idx_n   = idx + 1'b1;
        state_n = SELECT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q     <= '0;
      eng_addr <= '0;
      wcnt     <= '0;
      data_q   <= '0;
      nack_q   <= 1'b0;
      temp     <= '0;
      valid    <= '0;
      err      <= '0;
`ifdef TEMP_ALARM_EN
      alarm    <= '0;
`endif
    end else begin
      if (en_load) en_q <= sens_en;
      if (addr_load) eng_addr <= BASE_ADDR | 7'(idx);
      if (wcnt_clr) begin
        wcnt <= '0;
      end else if (wcnt_inc) begin
        wcnt <= wcnt + 1'b1;
      end
      if (cap) begin
        data_q <= eng_data;
        nack_q <= eng_nack;
      end
      if (set_err) err[idx] <= 1'b1;
      if (set_good) begin
        temp[16*idx +: 16] <= data_q;
        valid[idx]         <= 1'b1;
        err[idx]           <= 1'b0;
`ifdef TEMP_ALARM_EN
        alarm[idx] <= ($signed(data_q[15:7]) >= thresh);
`endif
      end
    end
  end

endmodule

// File: tb/tb_i2c_poll_sched.sv
// Scoreboard bench for i2c_poll_sched with a behavioural read engine.
module tb_i2c_poll_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  sens_en;
  logic        eng_start;
  logic [6:0]  eng_addr;
  logic        eng_busy;
  logic        eng_done;
  logic        eng_nack;
  logic [15:0] eng_data;
  logic [63:0] temp;
  logic [3:0]  valid;
  logic [3:0]  err;
  logic        sweep_done;
`ifdef TEMP_ALARM_EN
  logic signed [8:0] thresh = 9'sd50;
  logic [3:0]  alarm;
`endif

  int checks = 0;
  int passes = 0;
  int starts = 0;
  int sweeps = 0;
  int pend = 0;
  logic [6:0] pend_addr;
  logic [6:0] nack_addr = 7'h7f;
  logic [6:0] hang_addr = 7'h7f;
  logic [15:0] rd_data = 16'h1980;
  logic [6:0] exp_q[$];
  logic [6:0] e;

  always #5 clk = ~clk;

  i2c_poll_sched #(
    .N_SENS(4),
    .POLL_CYCLES(100),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sens_en   (sens_en),
    .eng_start (eng_start),
    .eng_addr  (eng_addr),
    .eng_busy  (eng_busy),
    .eng_done  (eng_done),
    .eng_nack  (eng_nack),
    .eng_data  (eng_data),
    .temp      (temp),
    .valid     (valid),
    .err       (err),
`ifdef TEMP_ALARM_EN
    .thresh    (thresh),
    .alarm     (alarm),
`endif
    .sweep_done(sweep_done)
  );

  // engine model plus scoreboard pop on every eng_start
  always @(negedge clk) begin
    eng_done = 1'b0;
    eng_nack = 1'b0;
    if (!rst_n) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0 && pend_addr != hang_addr) begin
          eng_done = 1'b1;
          eng_nack = (pend_addr == nack_addr);
          eng_data = rd_data;
        end
      end
      if (eng_start) begin
        starts++;
        pend = 4;
        pend_addr = eng_addr;
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_addr: unexpected eng_start addr=%h", eng_addr);
        end else begin
          e = exp_q.pop_front();
          if (eng_addr !== e)
            $display("FAIL sb_addr: got %h want %h", eng_addr, e);
          else
            passes++;
        end
      end
      if (sweep_done) sweeps++;
    end
  end

  task automatic wait_sweep(input int bound, output bit ok);
    int s0;
    s0 = sweeps;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (sweeps != s0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic push_all();
    for (int i = 0; i < 4; i++) exp_q.push_back(7'h48 + 7'(i));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sens_en = 4'b0;
    eng_busy = 1'b0;
    eng_data = 16'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({eng_start, eng_addr, sweep_done} !== 9'h0)
      $display("FAIL rst_ctl: got %h want 0", {eng_start, eng_addr, sweep_done});
    else passes++;
    checks++;
    if (temp !== 64'h0) $display("FAIL rst_temp: got %h want 0", temp);
    else passes++;
    checks++;
    if ({valid, err} !== 8'h0) $display("FAIL rst_flags: got %h want 0", {valid, err});
    else passes++;
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    int s0, st0;
    s0 = sweeps;
    st0 = starts;
    sens_en = 4'b0000;
    repeat (250) @(negedge clk);
    checks++;
    if (sweeps - s0 !== 0) $display("FAIL idle_sweeps: got %0d want 0", sweeps - s0);
    else passes++;
    checks++;
    if (starts - st0 !== 0) $display("FAIL idle_starts: got %0d want 0", starts - st0);
    else passes++;
  endtask

  task automatic test_all();
    int st0;
    bit ok;
    st0 = starts;
    rd_data = 16'h1980;
    sens_en = 4'b1111;
    push_all();
    wait_sweep(300, ok);
    checks++;
    if (!ok) $display("FAIL all_sweep: got timeout want sweep_done");
    else passes++;
    checks++;
    if (starts - st0 !== 4) $display("FAIL all_starts: got %0d want 4", starts - st0);
    else passes++;
    checks++;
    if ({valid, err} !== 8'hf0) $display("FAIL all_flags: got %h want f0", {valid, err});
    else passes++;
    checks++;
    if (temp !== {4{16'h1980}}) $display("FAIL all_temp: got %h want %h", temp, {4{16'h1980}});
    else passes++;
    @(negedge clk);
    checks++;
    if (sweep_done !== 1'b0) $display("FAIL all_pulse: got %b want 0", sweep_done);
    else passes++;
  endtask

  task automatic test_nack();
    bit ok;
    nack_addr = 7'h49;
    rd_data = 16'h2000;
    push_all();
    wait_sweep(300, ok);
    checks++;
    if (!ok) $display("FAIL nack_sweep: got timeout want sweep_done");
    else passes++;
    checks++;
    if (err !== 4'b0010) $display("FAIL nack_err: got %b want 0010", err);
    else passes++;
    checks++;
    if (temp[31:16] !== 16'h1980) $display("FAIL nack_temp1: got %h want 1980", temp[31:16]);
    else passes++;
    checks++;
    if (valid !== 4'b1111 || temp[15:0] !== 16'h2000)
      $display("FAIL nack_other: got %b/%h want 1111/2000", valid, temp[15:0]);
    else passes++;
    nack_addr = 7'h7f;
  endtask

  task automatic test_timeout();
    int errk, sdk;
    bit seen;
    hang_addr = 7'h4b;
    rd_data = 16'h2100;
    push_all();
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (eng_start && eng_addr == 7'h4b) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) $display("FAIL to_start: got none want start for 4b");
    else passes++;
    errk = 0;
    sdk = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (sweep_done) sdk = k;
      if (err[3]) begin
        errk = k;
        break;
      end
    end
    checks++;
    if (errk < 50 || errk > 51) $display("FAIL to_err_delay: got %0d want 50..51", errk);
    else passes++;
    checks++;
    if (sdk == 0) $display("FAIL to_sweep: got no sweep_done want pulse");
    else passes++;
    checks++;
    if (temp[63:48] !== 16'h2000 || temp[15:0] !== 16'h2100 || valid !== 4'hf)
      $display("FAIL to_data: got %h/%h/%b want 2000/2100/1111",
               temp[63:48], temp[15:0], valid);
    else passes++;
    hang_addr = 7'h7f;
  endtask

  task automatic test_busy();
    int st0;
    bit seen, ok;
    sens_en = 4'b0001;
    eng_busy = 1'b1;
    rd_data = 16'h0a80;
    st0 = starts;
    exp_q.push_back(7'h48);
    repeat (150) @(negedge clk);
    checks++;
    if (starts !== st0) $display("FAIL busy_hold: got %0d starts want 0", starts - st0);
    else passes++;
    eng_busy = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (starts != st0) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) $display("FAIL busy_release: got no start want start");
    else passes++;
    wait_sweep(50, ok);
    checks++;
    if (!ok || temp[15:0] !== 16'h0a80)
      $display("FAIL busy_store: got %b/%h want 1/0a80", ok, temp[15:0]);
    else passes++;
  endtask

  task automatic test_subset();
    int st0;
    bit ok;
    rst_n = 1'b0;
    exp_q.delete();
    sens_en = 4'b0101;
    rd_data = 16'h1980;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(7'h48);
    exp_q.push_back(7'h4a);
    st0 = starts;
    wait_sweep(300, ok);
    checks++;
    if (!ok) $display("FAIL sub_sweep: got timeout want sweep_done");
    else passes++;
    checks++;
    if (starts - st0 !== 2) $display("FAIL sub_starts: got %0d want 2", starts - st0);
    else passes++;
    checks++;
    if ({valid, err} !== 8'h50) $display("FAIL sub_flags: got %h want 50", {valid, err});
    else passes++;
    checks++;
    if (temp !== 64'h0000_1980_0000_1980)
      $display("FAIL sub_temp: got %h want 0000198000001980", temp);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int k0;
    bit seen, ok;
    sens_en = 4'b1111;
    push_all();
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (eng_start) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) $display("FAIL mid_start: got none want eng_start");
    else passes++;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({eng_start, eng_addr, sweep_done} !== 9'h0)
      $display("FAIL mid_ctl: got %h want 0", {eng_start, eng_addr, sweep_done});
    else passes++;
    checks++;
    if (temp !== 64'h0 || {valid, err} !== 8'h0)
      $display("FAIL mid_data: got %h/%h want 0/0", temp, {valid, err});
    else passes++;
    exp_q.delete();
    repeat (3) @(negedge clk);
    push_all();
    rst_n = 1'b1;
    k0 = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (eng_start) begin
        k0 = k;
        break;
      end
    end
    checks++;
    if (k0 != 101) $display("FAIL mid_first_start: got cycle %0d want 101", k0);
    else passes++;
    wait_sweep(100, ok);
    checks++;
    if (!ok || valid !== 4'hf) $display("FAIL mid_resume: got %b/%b want 1/1111", ok, valid);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_all();
    test_nack();
    test_timeout();
    test_busy();
    test_subset();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d want 0", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
